// File: rtl/pcm_fs_pkg.sv
// pcm_fs_pkg: shared definitions for the pcm_fs_sampler slice.
//   ACC_W  - phase accumulator width
//   rate_e - run-time rate codes (0..3 = 32 / 44.1 / 48 / 96 kHz)
//   fs_hz  - sample rate in Hz for a rate code
package pcm_fs_pkg;

  localparam int unsigned ACC_W = 32;

  typedef enum logic [1:0] {
    RATE_32K  = 2'd0,
    RATE_44K1 = 2'd1,
    RATE_48K  = 2'd2,
    RATE_96K  = 2'd3
  } rate_e;

  function automatic logic [ACC_W-1:0] fs_hz(input rate_e code);
    logic [ACC_W-1:0] hz;
    case (code)
      RATE_32K:  hz = ACC_W'(32000);
      RATE_44K1: hz = ACC_W'(44100);
      RATE_48K:  hz = ACC_W'(48000);
      default:   hz = ACC_W'(96000);
    endcase
    return hz;
  endfunction

endpackage

// File: rtl/fs_phase_acc.sv
// fs_phase_acc: fractional phase accumulator producing the fs tick and strobe.
//   clk, reset_n - pixel clock, async active-low reset
//   rate_sel     - requested rate code, adopted only at a tick
//   tick         - combinational: this cycle completes a sample period
//   pcm_fs       - registered fs strobe, rises the cycle after tick
module fs_phase_acc
  import pcm_fs_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 74250000,
  parameter logic [1:0]  RESET_RATE    = 2'd2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] rate_sel,
  output logic       tick,
  output logic       pcm_fs
);

  localparam logic [ACC_W-1:0] CLK_LIM  = ACC_W'(CLOCK_FREQ_HZ);
  localparam logic [ACC_W-1:0] HALF_LIM = ACC_W'(CLOCK_FREQ_HZ / 2);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;
  rate_e            rate_reg;

  // acc < 2^31 and fs < 2^31, so the sum cannot wrap 32 bits.
  always_comb begin
    nxt  = acc + fs_hz(rate_reg);
    tick = (nxt >= CLK_LIM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      rate_reg <= rate_e'(RESET_RATE);
      pcm_fs   <= 1'b0;
    end else begin
      acc <= tick ? (nxt - CLK_LIM) : nxt;
      if (tick) begin
        rate_reg <= rate_e'(rate_sel);
        pcm_fs   <= 1'b1;
      end else if (nxt >= HALF_LIM) begin
        pcm_fs <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pcm_fs_sampler.sv
// pcm_fs_sampler: fs generator plus one-deep PCM holding buffer for hdmi_tx.
//   clk, reset_n          - pixel clock, async active-low reset
//   rate_sel              - 0/1/2/3 = 32/44.1/48/96 kHz, applied at a sample boundary
//   mute                  - zero the sample taken at the next tick
//   in_valid/in_ready     - upstream handshake, in_data channel 0 in LSBs
//   underrun_clr          - clears sticky underrun (and counter when present)
//   pcm_fs, pcm_data      - fs strobe and current output sample
//   underrun              - sticky: a tick found the buffer empty
//   underrun_cnt          - saturating underrun count, only with PCMFS_UNDERRUN_CNT_EN
module pcm_fs_sampler
  import pcm_fs_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ    = 74250000,
  parameter int unsigned CHANNELS         = 2,
  parameter int unsigned PCM_WIDTH        = 24,
  parameter logic [1:0]  RESET_RATE       = 2'd2,
  parameter bit          HOLD_ON_UNDERRUN = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [1:0]                    rate_sel,
  input  logic                          mute,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHANNELS*PCM_WIDTH-1:0] in_data,
  input  logic                          underrun_clr,
  output logic                          pcm_fs,
  output logic [CHANNELS*PCM_WIDTH-1:0] pcm_data,
  output logic                          underrun
`ifdef PCMFS_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                   underrun_cnt
`endif
);

  localparam int unsigned DW = CHANNELS * PCM_WIDTH;

  logic          tick;
  logic          full;
  logic [DW-1:0] buffer;
  logic          xfer;
  logic          unr_set;

  fs_phase_acc #(
    .CLOCK_FREQ_HZ (CLOCK_FREQ_HZ),
    .RESET_RATE    (RESET_RATE)
  ) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .rate_sel (rate_sel),
    .tick     (tick),
    .pcm_fs   (pcm_fs)
  );

  assign in_ready = ~full;

  always_comb begin
    xfer    = in_valid & ~full;
    unr_set = tick & ~full;
  end

  // A transfer landing on an empty-buffer tick still counts as an underrun
  // for that tick, but fills the buffer for the following one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full     <= 1'b0;
      buffer   <= '0;
      pcm_data <= '0;
      underrun <= 1'b0;
    end else begin
      full <= xfer | (full & ~tick);
      if (xfer) begin
        buffer <= in_data;
      end
      if (tick) begin
        if (full) begin
          pcm_data <= mute ? '0 : buffer;
        end else if (!HOLD_ON_UNDERRUN) begin
          pcm_data <= '0;
        end
      end
      if (unr_set) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

`ifdef PCMFS_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      underrun_cnt <= '0;
    end else if (underrun_clr) begin
      underrun_cnt <= unr_set ? 16'd1 : 16'd0;
    end else if (unr_set && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pcm_fs_sampler.sv
module tb_pcm_fs_sampler;

  localparam int unsigned CLK_HZ   = 7425000;
  localparam int unsigned CH       = 2;
  localparam int unsigned PW       = 24;
  localparam int unsigned DW       = CH * PW;
  localparam logic [1:0]  RST_RATE = 2'd2;
  localparam bit          HOLD     = 1'b1;
  localparam logic [DW-1:0] HOLD_VAL = {2{24'h123456}};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    rate_sel = RST_RATE;
  logic          mute = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          underrun_clr = 1'b0;
  logic          in_ready;
  logic          pcm_fs;
  logic [DW-1:0] pcm_data;
  logic          underrun;
`ifdef PCMFS_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  always #5 clk = ~clk;

  pcm_fs_sampler #(
    .CLOCK_FREQ_HZ    (CLK_HZ),
    .CHANNELS         (CH),
    .PCM_WIDTH        (PW),
    .RESET_RATE       (RST_RATE),
    .HOLD_ON_UNDERRUN (HOLD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rate_sel     (rate_sel),
    .mute         (mute),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .underrun_clr (underrun_clr),
    .pcm_fs       (pcm_fs),
    .pcm_data     (pcm_data),
    .underrun     (underrun)
`ifdef PCMFS_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state, expressed as sample-level behaviour.
  logic          m_full;
  logic [DW-1:0] m_buf;
  logic [DW-1:0] m_data;
  logic          m_unr;
  int unsigned   m_cnt;
  logic [1:0]    m_rate;
  logic [1:0]    m_prev_rate;
  bit            const_rate;
  bit            prev_fs;
  bit            last_rose;
  longint        cyc;
  longint        last_rise;
  longint        last_spacing;
  longint        last_high;
  int            rises;

  function automatic longint fsv(input logic [1:0] r);
    case (r)
      2'd0:    return 32000;
      2'd1:    return 44100;
      2'd2:    return 48000;
      default: return 96000;
    endcase
  endfunction

  function automatic bit in_range(input longint x, input longint lo, input longint hi);
    return (x >= lo) && (x <= hi);
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full      = 1'b0;
    m_buf       = '0;
    m_data      = '0;
    m_unr       = 1'b0;
    m_cnt       = 0;
    m_rate      = RST_RATE;
    m_prev_rate = RST_RATE;
    const_rate  = 1'b1;
    prev_fs     = 1'b0;
    last_rose   = 1'b0;
    cyc         = 0;
    last_rise   = 0;
    rises       = 0;
  endtask

  // One clock: capture driven inputs, advance, update model, compare outputs.
  task automatic step();
    logic v, m, c, rose, fell, unr_set, xfer;
    logic [1:0] rs;
    logic [DW-1:0] d;
    longint n, f, lo;
    v = in_valid; m = mute; c = underrun_clr; rs = rate_sel; d = in_data;
    @(posedge clk);
    #1;
    cyc++;
    rose = pcm_fs & ~prev_fs;
    fell = ~pcm_fs & prev_fs;
    prev_fs = pcm_fs;
    last_rose = rose;
    if (const_rate) begin
      n = cyc - 1;
      f = fsv(RST_RATE);
      check1("tick_time", rose, ((n + 1) * f) / CLK_HZ != (n * f) / CLK_HZ);
    end
    xfer    = v & ~m_full;
    unr_set = rose & ~m_full;
    if (rose) begin
      rises++;
      last_spacing = cyc - last_rise;
      last_rise    = cyc;
      f = fsv(m_rate);
      if (m_rate == m_prev_rate)
        check1("tick_spacing", in_range(last_spacing, CLK_HZ / f, (CLK_HZ + f - 1) / f), 1'b1);
      m_prev_rate = m_rate;
      m_rate      = rs;
      if (m_full) begin
        m_data = m ? '0 : m_buf;
        m_full = 1'b0;
      end else if (!HOLD) begin
        m_data = '0;
      end
    end
    if (fell) begin
      last_high = cyc - last_rise;
      if (m_rate == m_prev_rate) begin
        lo = CLK_HZ / (2 * fsv(m_rate));
        check1("fs_high_time", in_range(last_high, lo, lo + 1), 1'b1);
      end
    end
    if (c) begin
      m_unr = unr_set;
      m_cnt = unr_set ? 1 : 0;
    end else if (unr_set) begin
      m_unr = 1'b1;
      if (m_cnt < 65535) m_cnt++;
    end
    if (xfer) begin
      m_buf  = d;
      m_full = 1'b1;
    end
    checkw("pcm_data", 64'(pcm_data), 64'(m_data));
    check1("in_ready", in_ready, ~m_full);
    check1("underrun", underrun, m_unr);
`ifdef PCMFS_UNDERRUN_CNT_EN
    checkw("underrun_cnt", 64'(underrun_cnt), 64'(m_cnt));
`endif
  endtask

  task automatic wait_rises(input int k);
    int got = 0;
    int guard = 0;
    while (got < k && guard < k * 400) begin
      step();
      guard++;
      if (last_rose) got++;
    end
    checkw("rise_timeout", 64'(got), 64'(k));
  endtask

  // Asynchronous reset mid-cycle, outputs checked before any clock edge.
  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    #1;
    check1("rst_pcm_fs", pcm_fs, 1'b0);
    checkw("rst_pcm_data", 64'(pcm_data), 64'd0);
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_underrun", underrun, 1'b0);
`ifdef PCMFS_UNDERRUN_CNT_EN
    checkw("rst_underrun_cnt", 64'(underrun_cnt), 64'd0);
`endif
    rate_sel = RST_RATE;
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    longint f0;
    int      first_tick_eval;
    model_reset();

    // Power-on reset.
    #12;
    do_reset();

    // Continuous source at 48 kHz: exact edge count over 1/1000 s.
    in_valid = 1'b1;
    for (int i = 0; i < int'(CLK_HZ / 1000); i++) begin
      in_data = DW'({$urandom, $urandom});
      step();
    end
    checkw("fs_edges_1ms", 64'(rises), 64'((longint'(CLK_HZ / 1000) * fsv(RST_RATE)) / CLK_HZ));
    check1("no_underrun_streaming", underrun, 1'b0);

    // Sparse random source, mute and clear traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 149) < 2);
      in_data      = DW'({$urandom, $urandom});
      mute         = ($urandom_range(0, 7) == 0);
      underrun_clr = ($urandom_range(0, 63) == 0);
      step();
    end
    mute = 1'b0;
    underrun_clr = 1'b0;

    // Rate switch 48k -> 32k mid-period.
    in_valid = 1'b1;
    wait_rises(1);
    repeat (70) step();
    rate_sel   = 2'd0;
    const_rate = 1'b0;
    wait_rises(1);
    check1("rate_old_period", in_range(last_spacing, 154, 155), 1'b1);
    wait_rises(2);
    check1("rate_new_period", in_range(last_spacing, 232, 233), 1'b1);
    wait_rises(1);
    check1("rate_new_period2", in_range(last_spacing, 232, 233), 1'b1);

    // Short random burst at 96k, then back to 48k.
    rate_sel = 2'd3;
    for (int i = 0; i < 1500; i++) begin
      in_valid     = ($urandom_range(0, 59) == 0);
      in_data      = DW'({$urandom, $urandom});
      mute         = ($urandom_range(0, 7) == 0);
      underrun_clr = ($urandom_range(0, 63) == 0);
      step();
    end
    mute = 1'b0;
    underrun_clr = 1'b0;
    rate_sel = RST_RATE;
    in_valid = 1'b1;
    wait_rises(3);

    // Hold on underrun, then simultaneous set and clear.
    in_valid = 1'b0;
    wait_rises(1);
    in_data  = HOLD_VAL;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check1("hold_accepted", in_ready, 1'b0);
    wait_rises(1);
    checkw("hold_first", 64'(pcm_data), 64'(HOLD_VAL));
    wait_rises(1);
    checkw("hold_repeat", 64'(pcm_data), 64'(HOLD_VAL));
    check1("hold_flag", underrun, 1'b1);
    underrun_clr = 1'b1;
    step();
    check1("clr_clears", underrun, 1'b0);
    wait_rises(1);
    check1("set_beats_clr", underrun, 1'b1);
    step();
    check1("clr_after_set", underrun, 1'b0);
    underrun_clr = 1'b0;

    // Reset mid-period with a buffered sample pending.
    in_valid = 1'b1;
    in_data  = DW'({$urandom, $urandom}) | DW'(1);
    wait_rises(1);
    step();
    step();
    in_valid = 1'b0;
    repeat (30) step();
    check1("pre_reset_full", in_ready, 1'b0);
    check1("pre_reset_fs", pcm_fs, 1'b1);
    do_reset();

    // Transfer exactly on the first tick after reset, buffer empty.
    f0 = fsv(RST_RATE);
    first_tick_eval = int'((longint'(CLK_HZ) + f0 - 1) / f0) - 1;
    repeat (first_tick_eval) step();
    in_data  = {24'hABCDEF, 24'h654321};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check1("coincide_tick", last_rose, 1'b1);
    check1("coincide_underrun", underrun, 1'b1);
    checkw("coincide_out_zero", 64'(pcm_data), 64'd0);
    check1("coincide_buffered", in_ready, 1'b0);
    wait_rises(1);
    checkw("coincide_next_tick", 64'(pcm_data), 64'({24'hABCDEF, 24'h654321}));

    // Muted sample is consumed, output zero.
    in_data  = {24'h111111, 24'h222222};
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    mute     = 1'b1;
    check1("mute_buffered", in_ready, 1'b0);
    wait_rises(1);
    checkw("mute_zero", 64'(pcm_data), 64'd0);
    check1("mute_consumed", in_ready, 1'b1);
    mute = 1'b0;

    // Three underruns from a clean reset.
    step();
    do_reset();
    wait_rises(3);
    check1("three_underruns_flag", underrun, 1'b1);
`ifdef PCMFS_UNDERRUN_CNT_EN
    checkw("three_underruns_cnt", 64'(underrun_cnt), 64'd3);
`endif
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check1("final_clr", underrun, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
